bcd_decoder: RTL
================

Name: bcd_decoder

Overview:
- Converts a signed 3-digit BCD value back into the 9-bit sign-magnitude binary format used by bcd_encoder.
- Binary format: bit 8 = sign, [7:0] = magnitude.
- Performs the inverse of bcd_encoder: its `data` digit bus feeds this block, so binary → BCD → binary round-trips are possible.
- Digit-serial multiply-accumulate, one digit per clock, with valid/ready handshakes on both sides.

Parameters:
- NUM_DIGITS, 3, number of magnitude BCD digits; digit index NUM_DIGITS is the sign digit.
- MAG_W, 8, binary magnitude width; bin_out width is MAG_W+1.
- SIGN_NEG, 4'hA, sign-digit code meaning negative.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  bcd_in holds a value to convert.
- in_ready  output  1  block can accept; high only in IDLE.
- bcd_in  input  [NUM_DIGITS:0][3:0]  digit 3 = sign digit, digits 2..0 = hundreds, tens, units.
- out_valid  output  1  bin_out/out_err hold a result.
- out_ready  input  1  consumer accepts the result.
- bin_out  output  MAG_W+1  bit 8 = sign, [7:0] = magnitude.
- out_err  output  1  result invalid; bin_out forced to 0.

Behaviour:
- Reset (async, any state): state=IDLE, in_ready=1, out_valid=0, out_err=0, bin_out=0, accumulator=0, digit index=0.
- States: IDLE, CONV, DONE.
- IDLE:
  - in_ready=1.
  - On a rising edge with in_valid=1: capture bcd_in into a local register, acc=0, idx=NUM_DIGITS-1, go to CONV.
  - Input may change freely after acceptance.
- CONV:
  - in_ready=0.
  - Each edge: acc = acc*10 + digit[idx], with *10 implemented as (acc<<3)+(acc<<1).
  - acc width = ceil(log2(10^NUM_DIGITS)) = 10 bits by default; no truncation inside CONV.
  - idx decrements each edge; on the edge processing idx=0, go to DONE and register the result.
- Latency: out_valid rises exactly NUM_DIGITS clocks (3) after the accepting edge.
- Error, out_err=1 and bin_out=0, when any of:
  - any magnitude digit > 9;
  - sign digit not in {4'h0, 4'hF, SIGN_NEG};
  - final acc > 2^MAG_W-1 (255).
- Sign handling:
  - 4'h0 and 4'hF (blank) = positive; SIGN_NEG = negative.
  - Negative zero normalises to 9'h000.
- DONE:
  - out_valid=1; bin_out and out_err held stable until out_ready=1.
  - On the edge with out_ready=1: out_valid=0, go to IDLE.
  - No accept in the same cycle; in_ready rises the following cycle.
- in_valid while not IDLE is ignored; no buffering.
- Reset mid-CONV or in DONE aborts the conversion; the pending result is discarded.

Test Plan:
- Reset:
  - Assert rst asynchronously between edges → in_ready=1, out_valid=0, bin_out=0, out_err=0 immediately.
  - Release; hold in_valid=0 for 5 cycles → outputs unchanged.
- Accept {0,2,5,5}, out_ready=1:
  - out_valid=1 exactly 3 clocks after the accept edge.
  - bin_out=9'h0FF, out_err=0.
  - in_ready=1 one clock after the result is consumed.
- Signed and normalisation cases:
  - {A,1,2,8} → bin_out=9'b1_1000_0000.
  - {F,0,0,7} → 9'h007.
  - {A,0,0,0} → 9'h000.
- Error cases, each → out_err=1, bin_out=0, latency unchanged:
  - {0,2,5,6} (overflow);
  - {0,1,C,0} (bad digit);
  - {3,0,0,1} (bad sign).
- Backpressure and mid-operation events:
  - Hold out_ready=0 for 6 cycles after out_valid → bin_out/out_err stable, in_ready=0, new in_valid ignored.
  - Assert rst one cycle into CONV → IDLE, and no out_valid is ever produced for that input.
- Round trip: chain bcd_encoder → bcd_decoder, sweep bin_v from 0 in steps of 9'h024 across the full 9-bit range → every decoded bin_out equals the encoder input, out_err=0.

Source files
------------

// File: rtl/bcd_decoder.sv
// bcd_decoder: converts a signed BCD value (sign digit plus NUM_DIGITS magnitude
// digits) into a sign-magnitude binary word. This is the inverse of bcd_encoder.
// The conversion is a digit-serial multiply-accumulate: one digit per clock,
// starting with the most significant digit. Both sides use valid/ready handshakes.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   bcd_in holds a value to convert
//   in_ready   block can accept a new value (high only while idle)
//   bcd_in     digit NUM_DIGITS = sign digit, lower digits = magnitude, MSD first
//   out_valid  bin_out / out_err hold a result
//   out_ready  consumer accepts the result
//   bin_out    bit MAG_W = sign, [MAG_W-1:0] = magnitude
//   out_err    result invalid (bad digit, bad sign or overflow); bin_out is 0
module bcd_decoder #(
    parameter int unsigned NUM_DIGITS = 3,
    parameter int unsigned MAG_W      = 8,
    parameter logic [3:0]  SIGN_NEG   = 4'hA
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NUM_DIGITS:0][3:0]  bcd_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [MAG_W:0]            bin_out,
    output logic                      out_err
);

    // Wide enough for any valid NUM_DIGITS-digit decimal value.
    localparam int unsigned ACC_W = $clog2(10 ** NUM_DIGITS);
    localparam int unsigned IDX_W = $clog2(NUM_DIGITS + 1);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [ACC_W-1:0] MAG_MAX  = ACC_W'((1 << MAG_W) - 1);

    typedef enum logic [1:0] {
        StIdle,
        StConv,
        StDone
    } state_t;

    state_t                     state_q;
    logic [NUM_DIGITS:0][3:0]   bcd_q;
    logic [ACC_W-1:0]           acc_q;
    logic [IDX_W-1:0]           idx_q;
    logic                       in_ready_q;
    logic                       out_valid_q;
    logic [MAG_W:0]             bin_out_q;
    logic                       out_err_q;

    logic [3:0]                 cur_digit;
    logic [3:0]                 sign_digit;
    logic [ACC_W-1:0]           acc_next;
    logic                       digit_bad;
    logic                       sign_bad;
    logic                       overflow;
    logic                       result_err;
    logic                       result_neg;

    always_comb begin
        cur_digit  = bcd_q[idx_q];
        sign_digit = bcd_q[NUM_DIGITS];
        // acc * 10 as a shift-add
        acc_next   = (acc_q << 3) + (acc_q << 1) + ACC_W'(cur_digit);

        digit_bad = 1'b0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (bcd_q[i] > 4'd9) begin
                digit_bad = 1'b1;
            end
        end

        sign_bad   = !((sign_digit == 4'h0) || (sign_digit == 4'hF) ||
                       (sign_digit == SIGN_NEG));
        overflow   = acc_next > MAG_MAX;
        result_err = digit_bad || sign_bad || overflow;
        // Negative zero normalises to positive zero.
        result_neg = (sign_digit == SIGN_NEG) && (acc_next != '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            bcd_q       <= '0;
            acc_q       <= '0;
            idx_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            bin_out_q   <= '0;
            out_err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        bcd_q      <= bcd_in;
                        acc_q      <= '0;
                        idx_q      <= IDX_LAST;
                        in_ready_q <= 1'b0;
                        state_q    <= StConv;
                    end
                end
                StConv: begin
                    acc_q <= acc_next;
                    if (idx_q == '0) begin
                        out_valid_q <= 1'b1;
                        out_err_q   <= result_err;
                        bin_out_q   <= result_err ? '0 :
                                       {result_neg, acc_next[MAG_W-1:0]};
                        state_q     <= StDone;
                    end else begin
                        idx_q <= idx_q - IDX_W'(1);
                    end
                end
                StDone: begin
                    // in_ready returns next cycle, so no accept on the consume edge.
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign bin_out   = bin_out_q;
    assign out_err   = out_err_q;

endmodule
